// File: rtl/complex_add_subb_pipe_pkg.sv
// Shared constants for the pipelined complex add/subtract: default widths
// and the per-stage chunk width derivation.
package complex_add_subb_pipe_pkg;

   localparam int W_DEF      = 16;
   localparam int STAGES_DEF = 4;

   function automatic int chunk_w(input int w, input int stages);
      return w / stages;
   endfunction

endpackage

// File: rtl/add_chunk_stage.sv
// One pipeline stage of a chunked ripple adder: resolves chunk K and
// forwards operands, partial sum and carry to the next stage.
module add_chunk_stage #(
   parameter int W  = 16,
   parameter int CW = 4,
   parameter int K  = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [W-1:0] i_s,
   input  logic         i_c,
   output logic [W-1:0] o_a,
   output logic [W-1:0] o_b,
   output logic [W-1:0] o_s,
   output logic         o_c
);

   logic [CW:0]  w_sum;
   logic [W-1:0] w_s;

   // Upper bits of i_s are still zero here, so OR-ing the chunk in is exact.
   always_comb begin
      w_sum = {1'b0, i_a[K*CW +: CW]} + {1'b0, i_b[K*CW +: CW]} + {{CW{1'b0}}, i_c};
      w_s   = i_s | (W'(w_sum[CW-1:0]) << (K*CW));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_a <= '0;
         o_b <= '0;
         o_s <= '0;
         o_c <= 1'b0;
      end else if (i_en) begin
         o_a <= i_a;
         o_b <= i_b;
         o_s <= w_s;
         o_c <= w_sum[CW];
      end
   end

endmodule

// File: rtl/complex_add_subb_pipe.sv
// Pipelined complex adder with per-operand negate, valid/ready flow control
// and a sticky signed-overflow flag.
module complex_add_subb_pipe
   import complex_add_subb_pipe_pkg::*;
#(
   parameter int W      = W_DEF,
   parameter int STAGES = STAGES_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         subb_a_x,
   input  logic         subb_a_y,
   input  logic         subb_b_x,
   input  logic         subb_b_y,
   input  logic [W-1:0] a_x,
   input  logic [W-1:0] a_y,
   input  logic [W-1:0] b_x,
   input  logic [W-1:0] b_y,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] s_x,
   output logic [W-1:0] s_y,
   output logic         c_x,
   output logic         c_y,
   output logic         ovf_x,
   output logic         ovf_y,
   output logic         ovf_sticky,
   input  logic         ovf_clr
);

   localparam int CW = chunk_w(W, STAGES);

   logic                           w_stall;
   logic [STAGES:1]                r_vld;
   logic [STAGES:0]                w_vld;
   logic                           r_ovf_sticky;
   logic [1:0][W-1:0]              w_in_a, w_in_b;
   logic [1:0]                     w_neg_a, w_neg_b, w_ovf;
   logic [1:0][STAGES:0][W-1:0]    w_a, w_b, w_s;
   logic [1:0][STAGES:0]           w_c;

   assign w_stall   = out_valid & ~out_ready;
   assign in_ready  = ~w_stall;
   assign out_valid = r_vld[STAGES];
   assign w_vld     = {r_vld, in_valid};

   assign w_in_a  = {a_y, a_x};
   assign w_in_b  = {b_y, b_x};
   assign w_neg_a = {subb_a_y, subb_a_x};
   assign w_neg_b = {subb_b_y, subb_b_x};

   // Data registers load only with a valid token, so bubbles leave the
   // last-stage result (and therefore the outputs) untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_vld <= '0;
      else if (!w_stall) r_vld <= w_vld[STAGES-1:0];
   end

   for (genvar c = 0; c < 2; c++) begin : g_comp
      assign w_a[c][0] = w_neg_a[c] ? -w_in_a[c] : w_in_a[c];
      assign w_b[c][0] = w_neg_b[c] ? -w_in_b[c] : w_in_b[c];
      assign w_s[c][0] = '0;
      assign w_c[c][0] = 1'b0;

      for (genvar k = 0; k < STAGES; k++) begin : g_stage
         add_chunk_stage #(.W(W), .CW(CW), .K(k)) u_stage (
            .clk  (clk),
            .rst  (rst),
            .i_en (w_vld[k] & ~w_stall),
            .i_a  (w_a[c][k]),
            .i_b  (w_b[c][k]),
            .i_s  (w_s[c][k]),
            .i_c  (w_c[c][k]),
            .o_a  (w_a[c][k+1]),
            .o_b  (w_b[c][k+1]),
            .o_s  (w_s[c][k+1]),
            .o_c  (w_c[c][k+1])
         );
      end

      assign w_ovf[c] = (w_a[c][STAGES][W-1] == w_b[c][STAGES][W-1]) &&
                        (w_s[c][STAGES][W-1] != w_a[c][STAGES][W-1]);
   end

   assign s_x   = w_s[0][STAGES];
   assign s_y   = w_s[1][STAGES];
   assign c_x   = w_c[0][STAGES];
   assign c_y   = w_c[1][STAGES];
   assign ovf_x = w_ovf[0];
   assign ovf_y = w_ovf[1];

   // A delivered overflow beats a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                           r_ovf_sticky <= 1'b0;
      else if (out_valid && out_ready && (|w_ovf))       r_ovf_sticky <= 1'b1;
      else if (ovf_clr)                                  r_ovf_sticky <= 1'b0;
   end

   assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_complex_add_subb_pipe.sv
// Directed bench for complex_add_subb_pipe at W=4, STAGES=2: vector table,
// streaming, stall, sticky-flag and mid-flight reset sequences.
module tb_complex_add_subb_pipe;

   localparam int W      = 4;
   localparam int STAGES = 2;

   typedef struct {
      logic [W-1:0] a_x, a_y, b_x, b_y;
      logic         sax, say, sbx, sby;
   } in_t;

   typedef struct {
      logic [W-1:0] s_x, s_y;
      logic         c_x, c_y, ovf_x, ovf_y;
   } out_t;

   typedef struct {
      in_t  i;
      out_t e;
   } vec_t;

   logic         clk = 1'b0, rst = 1'b1;
   logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
   logic         subb_a_x = 1'b0, subb_a_y = 1'b0, subb_b_x = 1'b0, subb_b_y = 1'b0;
   logic [W-1:0] a_x = '0, a_y = '0, b_x = '0, b_y = '0;
   logic [W-1:0] s_x, s_y;
   logic         c_x, c_y, ovf_x, ovf_y, ovf_sticky, ovf_clr = 1'b0;

   int   checks = 0, failures = 0;
   int   cyc = 0, n_out = 0;
   int   out_cyc [64];
   out_t q [$];
   out_t m_exp;
   vec_t tbl [5];

   complex_add_subb_pipe #(.W(W), .STAGES(STAGES)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .subb_a_x(subb_a_x), .subb_a_y(subb_a_y), .subb_b_x(subb_b_x), .subb_b_y(subb_b_y),
      .a_x(a_x), .a_y(a_y), .b_x(b_x), .b_y(b_y),
      .out_valid(out_valid), .out_ready(out_ready),
      .s_x(s_x), .s_y(s_y), .c_x(c_x), .c_y(c_y),
      .ovf_x(ovf_x), .ovf_y(ovf_y), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input out_t e);
      chk({name, ".s_x"},   s_x,   e.s_x);
      chk({name, ".c_x"},   c_x,   e.c_x);
      chk({name, ".ovf_x"}, ovf_x, e.ovf_x);
      chk({name, ".s_y"},   s_y,   e.s_y);
      chk({name, ".c_y"},   c_y,   e.c_y);
      chk({name, ".ovf_y"}, ovf_y, e.ovf_y);
   endtask

   // Reference: negate as 2^W - v, then a plain W+1-bit sum.
   function automatic logic [W+1:0] comp(input logic [W-1:0] a, b, input logic sa, sb);
      logic [W-1:0] oa, ob;
      logic [W:0]   sum;
      oa  = sa ? W'((1 << W) - int'(a)) : a;
      ob  = sb ? W'((1 << W) - int'(b)) : b;
      sum = (W+1)'(int'(oa) + int'(ob));
      return {sum[W-1:0], sum[W], (oa[W-1] == ob[W-1]) && (sum[W-1] != oa[W-1])};
   endfunction

   function automatic out_t model(input in_t v);
      out_t o;
      {o.s_x, o.c_x, o.ovf_x} = comp(v.a_x, v.b_x, v.sax, v.sbx);
      {o.s_y, o.c_y, o.ovf_y} = comp(v.a_y, v.b_y, v.say, v.sby);
      return o;
   endfunction

   function automatic vec_t mk(input int ax, bx, sax, sbx, ay, by, say, sby,
                               input int esx, ecx, eox, esy, ecy, eoy);
      vec_t v;
      v.i.a_x = W'(ax); v.i.b_x = W'(bx); v.i.sax = 1'(sax); v.i.sbx = 1'(sbx);
      v.i.a_y = W'(ay); v.i.b_y = W'(by); v.i.say = 1'(say); v.i.sby = 1'(sby);
      v.e.s_x = W'(esx); v.e.c_x = 1'(ecx); v.e.ovf_x = 1'(eox);
      v.e.s_y = W'(esy); v.e.c_y = 1'(ecy); v.e.ovf_y = 1'(eoy);
      return v;
   endfunction

   function automatic in_t stream_in(input int i);
      in_t v;
      v.a_x = W'(i * 3 + 1); v.b_x = W'(i * 5);  v.sax = 1'(i);      v.sbx = 1'(i >> 1);
      v.a_y = W'(15 - i);    v.b_y = W'(i * 7);  v.say = 1'(i >> 2); v.sby = 1'(i + 1);
      return v;
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input in_t v);
      int t;
      a_x = v.a_x; b_x = v.b_x; subb_a_x = v.sax; subb_b_x = v.sbx;
      a_y = v.a_y; b_y = v.b_y; subb_a_y = v.say; subb_b_y = v.sby;
      in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (!in_ready) begin
         failures++;
         $display("FAIL send_timeout actual=in_ready=0 required=in_ready=1");
      end else begin
         q.push_back(model(v));
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Scoreboard: every delivered handshake must match the head of the queue.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=s_x=%0d,s_y=%0d required=no_output", s_x, s_y);
         end else begin
            m_exp = q.pop_front();
            chk_out("scoreboard", m_exp);
         end
         if (n_out < 64) out_cyc[n_out] = cyc;
         n_out++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0, t;
      tbl[0] = mk(5, 3, 0, 0,   5, 3, 0, 1,   8, 0, 1,   2, 1, 0);
      tbl[1] = mk(3, 7, 1, 0,   0, 0, 1, 1,   4, 1, 0,   0, 0, 0);
      tbl[2] = mk(8, 8, 1, 0,   7, 1, 0, 0,   0, 1, 1,   8, 0, 1);
      tbl[3] = mk(15, 1, 0, 0,  6, 2, 1, 1,   0, 1, 0,   8, 1, 0);
      tbl[4] = mk(4, 9, 0, 1,   0, 5, 1, 0,  11, 0, 1,   5, 0, 0);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst.out_valid", out_valid, 0);
      chk("rst.in_ready", in_ready, 1);
      chk("rst.sticky", ovf_sticky, 0);
      chk_out("rst", '{s_x: '0, s_y: '0, c_x: 1'b0, c_y: 1'b0, ovf_x: 1'b0, ovf_y: 1'b0});
      @(posedge clk);
      #1 rst = 1'b0;

      // Table vectors, one at a time, with exact-latency checks
      for (int i = 0; i < 5; i++) begin
         send(tbl[i].i);
         @(negedge clk);
         chk($sformatf("tbl%0d.early_valid", i), out_valid, 0);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("tbl%0d.out_valid", i), out_valid, 1);
         chk_out($sformatf("tbl%0d", i), tbl[i].e);
         @(posedge clk);
         #1;
      end
      chk("sticky_after_ovf", ovf_sticky, 1);

      // Clear alone, then clear colliding with an overflowing handshake
      ovf_clr = 1'b1;
      @(posedge clk);
      #1 ovf_clr = 1'b0;
      chk("sticky_cleared", ovf_sticky, 0);
      send(tbl[0].i);
      @(posedge clk);
      #1;
      chk("sticky_pre_collide", ovf_sticky, 0);
      chk("collide.out_valid", out_valid, 1);
      ovf_clr = 1'b1;
      @(posedge clk);
      #1 ovf_clr = 1'b0;
      chk("sticky_set_wins", ovf_sticky, 1);

      // Back-to-back stream of 8
      n0 = n_out;
      for (int i = 0; i < 8; i++) send(stream_in(i));
      t = 0;
      while (n_out < n0 + 8 && t < 20) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("stream.count", n_out - n0, 8);
      chk("stream.consecutive", out_cyc[n0 + 7] - out_cyc[n0], 7);

      // Stall with a full pipe for 3 cycles
      out_ready = 1'b0;
      n0 = n_out;
      send(tbl[2].i);
      send(tbl[3].i);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("stall%0d.in_ready", i), in_ready, 0);
         chk($sformatf("stall%0d.out_valid", i), out_valid, 1);
         chk_out($sformatf("stall%0d", i), q[0]);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(tbl[4].i);
      t = 0;
      while (q.size() != 0 && t < 20) begin
         @(posedge clk);
         t++;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("stall.drained", q.size(), 0);
      chk("stall.count", n_out - n0, 3);

      // Reset with two sets in flight
      send(tbl[0].i);
      send(tbl[1].i);
      rst = 1'b1;
      #1;
      chk("midrst.out_valid", out_valid, 0);
      chk("midrst.in_ready", in_ready, 1);
      chk("midrst.sticky", ovf_sticky, 0);
      chk_out("midrst", '{s_x: '0, s_y: '0, c_x: 1'b0, c_y: 1'b0, ovf_x: 1'b0, ovf_y: 1'b0});
      q.delete();
      n0 = n_out;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("midrst.no_stale", n_out - n0, 0);
      chk("midrst.idle_valid", out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/complex_add_subb_pipe.md
COMPLEX_ADD_SUBB_PIPE -- requirements
Module: complex_add_subb_pipe

Interface
REQ-001 Parameter W, default 16, operand and result width per component; SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, default 4, number of pipeline stages; SHALL be 1..W.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  operand set present.
REQ-006 in_ready  out  1  block accepts operand set this cycle.
REQ-007 subb_a_x, subb_a_y, subb_b_x, subb_b_y  in  1 each  negate the matching operand.
REQ-008 a_x, a_y, b_x, b_y  in  W each  operands, two's complement.
REQ-009 out_valid  out  1  result present.
REQ-010 out_ready  in  1  downstream accepts result.
REQ-011 s_x, s_y  out  W each  sums.
REQ-012 c_x, c_y  out  1 each  unsigned carry out of each component.
REQ-013 ovf_x, ovf_y  out  1 each  signed overflow for this result.
REQ-014 ovf_sticky  out  1  OR of all ovf_x/ovf_y delivered since last clear.
REQ-015 ovf_clr  in  1  synchronous clear of ovf_sticky.

Function
REQ-016 Per component: op_a = subb_a ? (2^W - a) mod 2^W : a; op_b likewise; {c, s} = op_a + op_b as a W+1-bit unsigned sum.
REQ-017 ovf = (msb(op_a) == msb(op_b)) and (msb(s) != msb(op_a)); negating the most negative value yields itself, with no special case.
REQ-018 Adder split into STAGES chunks of W/STAGES bits; chunk k is resolved in stage k+1, with carry registered between stages; lower result bits and untouched upper operand bits are carried forward in pipeline registers.
REQ-019 Latency SHALL be exactly STAGES cycles from accepted input (in_valid & in_ready) to out_valid, absent stalls.
REQ-020 Throughput SHALL be one operand set per cycle when out_ready is held high.
REQ-021 stall = out_valid & ~out_ready; in_ready = ~stall. When stalled, every pipeline register, including valid bits, SHALL hold.
REQ-022 Outputs SHALL remain stable while out_valid & ~out_ready.
REQ-023 Bubbles (valid bit 0) SHALL propagate without affecting outputs; s, c and ovf hold their last values while out_valid = 0.
REQ-024 ovf_sticky sets on any cycle where out_valid & out_ready & (ovf_x | ovf_y).
REQ-025 If ovf_clr and a set condition occur in the same cycle, the set condition wins.
REQ-026 X and Y paths SHALL be independent; they share only the valid/stall control.

Reset
REQ-027 On rst, all stage valid bits SHALL clear immediately, making out_valid = 0 and in_ready = 1.
REQ-028 On rst, s_x = s_y = 0, c_x = c_y = 0, ovf_x = ovf_y = 0, and ovf_sticky = 0.
REQ-029 A reset asserted mid-operation SHALL discard all in-flight operand sets, with no output after release.
REQ-030 The first operand set may be accepted on the first rising edge after rst deasserts.

Structure
REQ-031 A shared header SHALL hold the default W and STAGES constants and the chunk-width derivation, for use by RTL and bench.
REQ-032 One sub-module, add_chunk_stage, SHALL implement one chunk: W/STAGES-bit add with carry-in/carry-out plus pass-through registers.
REQ-033 The top level SHALL instantiate one add_chunk_stage per stage per component and hold the shared valid/stall logic.

Verification (W=4, STAGES=2)
REQ-034 a_x=5, b_x=3, no subb -> after 2 cycles s_x=8, c_x=0, ovf_x=1, ovf_sticky=1.
REQ-035 a_y=5, b_y=3, subb_b_y=1 -> s_y=2, c_y=1, ovf_y=0.
REQ-036 a_x=3, b_x=7, subb_a_x=1 -> s_x=4, c_x=1, ovf_x=0; a=0, b=0, both subb -> s=0, c=0.
REQ-037 Back-to-back stream of 8 sets, out_ready=1 -> 8 results on 8 consecutive cycles, in order, each matching the model.
REQ-038 out_ready=0 for 3 cycles with a full pipe -> in_ready=0, outputs frozen, no loss or duplication after release.
REQ-039 rst pulsed with 2 sets in flight -> out_valid=0 immediately, all outputs 0, no stale result after release.
REQ-040 ovf_clr in the same cycle as an overflowing handshake -> ovf_sticky stays 1; ovf_clr alone -> ovf_sticky=0 on the next cycle.
REQ-041 The bench SHALL compare every handshake against a reference model and count mismatches as errors.
